// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared definitions for the data-memory arbiter.
//   arb_state_e : arbiter FSM encoding (ARB / LOCK0 / LOCK1)
//   NUM_PORTS   : number of requesters sharing the memory
package dmem_arb_pkg;

    localparam int unsigned NUM_PORTS = 2;

    typedef enum logic [1:0] {
        ARB   = 2'b00,
        LOCK0 = 2'b01,
        LOCK1 = 2'b10
    } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester and memory signals of the data-memory arbiter.
//   req/we/addr/wdata/lock 0,1 : requester command (held until gnt)
//   gnt/rvalid/rdata 0,1       : grant (combinational), registered read return
//   mem_*                      : single-word memory, combinational read, sync write
// Modports: slave = arbiter side, master = requesters plus memory side.
interface dmem_arbiter_if #(
    parameter int unsigned D_WIDTH = 32,
    parameter int unsigned A_WIDTH = 32
);
    logic               req0;
    logic               req1;
    logic               we0;
    logic               we1;
    logic [A_WIDTH-1:0] addr0;
    logic [A_WIDTH-1:0] addr1;
    logic [D_WIDTH-1:0] wdata0;
    logic [D_WIDTH-1:0] wdata1;
    logic               lock0;
    logic               lock1;
    logic               gnt0;
    logic               gnt1;
    logic               rvalid0;
    logic               rvalid1;
    logic [D_WIDTH-1:0] rdata0;
    logic [D_WIDTH-1:0] rdata1;
    logic               mem_we;
    logic               mem_re;
    logic [A_WIDTH-1:0] mem_waddr;
    logic [A_WIDTH-1:0] mem_raddr;
    logic [D_WIDTH-1:0] mem_wdata;
    logic [D_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
        input  mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output mem_we, mem_re, mem_waddr, mem_raddr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
        output mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  mem_we, mem_re, mem_waddr, mem_raddr, mem_wdata
    );

endinterface

// File: rtl/dmem_arb_rr.sv
// dmem_arb_rr: combinational two-way round-robin winner select.
//   req       in  request vector
//   elig      in  eligibility mask (lock ownership)
//   last_gnt  in  port granted most recently
//   win_valid out some eligible port is requesting
//   win       out winning port index (meaningful only when win_valid)
module dmem_arb_rr
    import dmem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] elig,
    input  logic                 last_gnt,
    output logic                 win_valid,
    output logic                 win
);

    logic [NUM_PORTS-1:0] eff_req;

    always_comb begin
        eff_req   = req & elig;
        win_valid = |eff_req;
        case (eff_req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            // Conflict: the port that did not win last time goes next.
            2'b11:   win = ~last_gnt;
            default: win = last_gnt;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between port 0 (CPU LSU) and port 1
// (debug/DMA). Round-robin grants, same-cycle grant, read data registered one
// cycle after the read grant.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : dmem_arbiter_if.slave (requester handshakes and memory port)
// Build option: define DMEM_ARB_LOCK_EN to honour lock0/lock1 (LOCK0/LOCK1
// states plus a forced-release counter bounded by LOCK_MAX). Without it the
// lock inputs are ignored and the arbiter is pure round-robin.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned D_WIDTH  = 32,
    parameter int unsigned A_WIDTH  = 32,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    logic [NUM_PORTS-1:0] req_vec;
    logic [NUM_PORTS-1:0] elig;
    logic                 win_valid;
    logic                 win;
    logic                 gnt_any;
    logic                 sel_we;
    logic [A_WIDTH-1:0]   sel_addr;
    logic [D_WIDTH-1:0]   sel_wdata;

    logic                 last_gnt_q;
    logic                 rvalid0_q;
    logic                 rvalid1_q;
    logic [D_WIDTH-1:0]   rdata0_q;
    logic [D_WIDTH-1:0]   rdata1_q;

    assign req_vec = {bus.req1, bus.req0};

    dmem_arb_rr u_rr (
        .req       (req_vec),
        .elig      (elig),
        .last_gnt  (last_gnt_q),
        .win_valid (win_valid),
        .win       (win)
    );

    // Grant and memory-port mux.
    always_comb begin
        gnt_any   = win_valid & ~rst;
        sel_we    = win ? bus.we1    : bus.we0;
        sel_addr  = win ? bus.addr1  : bus.addr0;
        sel_wdata = win ? bus.wdata1 : bus.wdata0;

        bus.gnt0      = gnt_any & ~win;
        bus.gnt1      = gnt_any &  win;
        bus.mem_we    = gnt_any &  sel_we;
        bus.mem_re    = gnt_any & ~sel_we;
        bus.mem_waddr = gnt_any ? sel_addr  : '0;
        bus.mem_raddr = gnt_any ? sel_addr  : '0;
        bus.mem_wdata = gnt_any ? sel_wdata : '0;
    end

    // Round-robin history and registered read return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            if (gnt_any) begin
                last_gnt_q <= win;
            end
            rvalid0_q <= gnt_any & ~win & ~sel_we;
            rvalid1_q <= gnt_any &  win & ~sel_we;
            if (gnt_any && !win && !sel_we) begin
                rdata0_q <= bus.mem_rdata;
            end
            if (gnt_any && win && !sel_we) begin
                rdata1_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;

`ifdef DMEM_ARB_LOCK_EN
    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_e       state_q;
    arb_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             sel_lock;

    assign sel_lock = win ? bus.lock1 : bus.lock0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt_inc is the number of locked cycles including the current one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cnt_inc = (cnt_q == CNT_W'(LOCK_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
        case (state_q)
            ARB: begin
                if (gnt_any && sel_lock) begin
                    state_d = win ? LOCK1 : LOCK0;
                    cnt_d   = '0;
                end
            end
            LOCK0, LOCK1: begin
                cnt_d = cnt_inc;
                // Forced release wins over a request to stay locked.
                if (cnt_inc == CNT_W'(LOCK_MAX)) begin
                    state_d = ARB;
                end else if (gnt_any && !sel_lock) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        elig = 2'b11;
        unique case (state_q)
            ARB:     elig = 2'b11;
            LOCK0:   elig = 2'b01;
            LOCK1:   elig = 2'b10;
            default: elig = 2'b11;
        endcase
    end
`else
    localparam int unsigned unused_lock_max = LOCK_MAX;
    logic unused_lock;

    assign unused_lock = bus.lock0 ^ bus.lock1;
    assign elig        = 2'b11;
`endif

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-word data memory between requester 0 (CPU load/store unit) and requester 1 (debug/DMA port). Grants are round-robin with optional bus locking for atomic read-modify-write. It drives the memory's combinational-read, synchronous-write port directly and returns registered read data one cycle after grant.

## Interface
- D_WIDTH, 32, data word width
- A_WIDTH, 32, byte address width (word-aligned, addr[1:0] ignored by memory)
- LOCK_MAX, 16, maximum consecutive locked cycles before forced release (≥1)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req0 / req1  in  1  request valid; held until grant
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  A_WIDTH  byte address
- wdata0 / wdata1  in  D_WIDTH  write data
- lock0 / lock1  in  1  keep ownership after this transfer
- gnt0 / gnt1  out  1  transfer accepted this cycle (combinational)
- rvalid0 / rvalid1  out  1  read data valid (registered, 1 cycle after read grant)
- rdata0 / rdata1  out  D_WIDTH  registered read data
- mem_we, mem_re  out  1  to memory
- mem_waddr, mem_raddr  out  A_WIDTH  to memory (both = granted address)
- mem_wdata  out  D_WIDTH  to memory
- mem_rdata  in  D_WIDTH  from memory (combinational)

## Operation
- One transfer per cycle; at most one of gnt0/gnt1 high.
- Granted port's we/addr/wdata drive mem_*: write → mem_we=1, mem_re=0; read → mem_re=1, mem_we=0. No grant → mem_we=mem_re=0, addresses/data 0.
- Round-robin: single requester wins; both requesting → winner is port not equal to last_gnt. last_gnt updates on every grant.
- Read grant on port n: mem_rdata captured into rdatan at edge; rvalidn=1 next cycle for exactly one cycle. rdatan holds value otherwise.
- FSM states ARB, LOCK0, LOCK1:
  - ARB: normal arbitration. Grant to port n with lockn=1 → LOCKn.
  - LOCKn: only port n may be granted; other port's req ignored (gnt=0). Grant to port n with lockn=0 → ARB. Lock counter reaching LOCK_MAX → ARB (forced release).
- Lock counter: cleared on entry to LOCKn, increments each cycle in LOCKn, saturates; release on the cycle count==LOCK_MAX.
- Back-to-back write then read to same address: write lands at edge, next-cycle read returns new data.

## Timing
- Reset values: state ARB, last_gnt=1 (port 0 wins first conflict), lock counter 0, rvalid0/1=0, rdata0/1=0; gnt0/1, mem_we, mem_re forced 0 while rst high.
- Grant latency 0 cycles (same cycle as req if eligible); read data latency 1 cycle.
- Requester must hold req/we/addr/wdata/lock stable until gnt sampled high; dropping req early is legal and cancels the request.
- rst asserted mid-lock: immediate return to ARB, pending rvalid discarded.
- Forced release cycle: port n's grant in that cycle still completes; next cycle arbitration is round-robin with last_gnt=n.

## Configuration
- DMEM_ARB_LOCK_EN defined: lock0/lock1 honoured, LOCK0/LOCK1 states and counter present.
- Undefined: lock inputs ignored, FSM permanently ARB, counter not built; pure round-robin.

## Structure
- Package dmem_arb_pkg: state encoding constants (ARB=2'b00, LOCK0=2'b01, LOCK1=2'b10), NUM_PORTS=2.
- Sub-module dmem_arb_rr: combinational 2-way round-robin winner select from req vector, eligibility mask and last_gnt.

## Test plan
- Reset, then req0 read addr 0x10 (mem holds 0xA5A5A5A5) → gnt0 same cycle, rvalid0=1 and rdata0=0xA5A5A5A5 next cycle.
- req0 and req1 both held continuously, reads → grants alternate 0,1,0,1 starting with port 0.
- Port 1 write 0xDEADBEEF to 0x20, next cycle port 0 read 0x20 → rdata0=0xDEADBEEF.
- (LOCK_EN) port 0 read with lock0=1 while req1 held, then write with lock0=0 → gnt1 stays 0 for both, gnt1 on following cycle.
- (LOCK_EN) port 1 locks and keeps lock1=1, LOCK_MAX=4 → port 0 granted no later than cycle after 4th locked cycle.
- Assert rst during LOCK0 with a read granted → rvalid0 stays 0, state ARB, next conflict granted to port 0.
